// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the fetch-address generator.
//   PC_RESET_VEC / PC_EXC_VEC   default reset and exception entry addresses
//   PC_ADDR_LO / PC_ADDR_HI     default legal fetch window (inclusive)
//   PC_STEP                     sequential increment in bytes
//   pc_src_e                    next-PC source chosen by the priority encoder
package pc_pkg;

   localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
   localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
   localparam logic [31:0] PC_ADDR_LO   = 32'h0000_3000;
   localparam logic [31:0] PC_ADDR_HI   = 32'h0000_4ffc;
   localparam int unsigned PC_STEP      = 4;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BR,
      SRC_PEND,
      SRC_EXC,
      SRC_ERET,
      SRC_HOLD
   } pc_src_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// pc_redirect_latch: holds one redirect target that arrived while fetch was frozen.
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (clears valid and address)
//   capture_i    store addr_i and mark valid (newer capture overwrites older)
//   addr_i       redirect target to capture
//   consume_i    pending target is being applied this edge; drop valid
//   clear_i      pending target is superseded (exception, ERET, live branch)
//   pend_valid_o a deferred redirect is held
//   pend_addr_o  the held redirect target
module pc_redirect_latch #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             capture_i,
   input  logic [WIDTH-1:0] addr_i,
   input  logic             consume_i,
   input  logic             clear_i,
   output logic             pend_valid_o,
   output logic [WIDTH-1:0] pend_addr_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] addr_q, addr_d;

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (clear_i || consume_i) begin
         valid_d = 1'b0;
      end else if (capture_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

   assign pend_valid_o = valid_q;
   assign pend_addr_o  = addr_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-address generator. Holds the PC and picks the next one from
// sequential, branch/jump, deferred-branch, exception and ERET sources; freezes
// on stall | xstall, latching any branch that arrives while frozen.
//   clk, reset (sync, active-high), stall, xstall       control
//   br_valid, br_target                                 D-stage redirect
//   exc_req                                             exception/interrupt -> EXC_VEC
//   eret_req, epc                                       return from exception
//   pc, pc_next (pc+STEP, comb), pend_valid, adel       outputs
// Build option: define PC_ADDR_CHECK_EN to drive adel from an alignment and
// range check on pc; otherwise adel is tied low.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
   parameter int unsigned      STEP      = PC_STEP,
   parameter logic [WIDTH-1:0] ADDR_LO   = WIDTH'(PC_ADDR_LO),
   parameter logic [WIDTH-1:0] ADDR_HI   = WIDTH'(PC_ADDR_HI)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             xstall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_next,
   output logic             pend_valid,
   output logic             adel
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_addr;
   logic             frz;
   pc_src_e          src;

   assign frz     = stall | xstall;
   assign pc_next = pc_q + WIDTH'(STEP);

   // Exception and ERET override a freeze; a live branch beats a stale pending one.
   always_comb begin
      src = SRC_SEQ;
      if (exc_req)         src = SRC_EXC;
      else if (eret_req)   src = SRC_ERET;
      else if (frz)        src = SRC_HOLD;
      else if (br_valid)   src = SRC_BR;
      else if (pend_valid) src = SRC_PEND;
   end

   always_comb begin
      pc_d = pc_next;
      unique case (src)
         SRC_EXC:  pc_d = EXC_VEC;
         SRC_ERET: pc_d = epc;
         SRC_HOLD: pc_d = pc_q;
         SRC_BR:   pc_d = br_target;
         SRC_PEND: pc_d = pend_addr;
         default:  pc_d = pc_next;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_VEC;
      else       pc_q <= pc_d;
   end

   pc_redirect_latch #(
      .WIDTH (WIDTH)
   ) u_latch (
      .clk_i        (clk),
      .rst_i        (reset),
      .capture_i    ((src == SRC_HOLD) && br_valid),
      .addr_i       (br_target),
      .consume_i    (src == SRC_PEND),
      .clear_i      ((src == SRC_EXC) || (src == SRC_ERET) || (src == SRC_BR)),
      .pend_valid_o (pend_valid),
      .pend_addr_o  (pend_addr)
   );

   assign pc = pc_q;

   // A mis-ordered fetch window is a configuration mistake; reject it at elaboration.
   if (ADDR_LO > ADDR_HI) begin : g_bad_window
      $error("pc_unit: ADDR_LO is above ADDR_HI");
   end

`ifdef PC_ADDR_CHECK_EN
   // Suppressed during reset so CP0 never sees a spurious AdEL from the pre-reset PC.
   assign adel = ~reset & ((pc_q[1:0] != 2'b00) | (pc_q < ADDR_LO) | (pc_q > ADDR_HI));
`else
   assign adel = 1'b0;
`endif

endmodule
